// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: takes a length-prefixed byte stream,
// packs three bytes into each 20-bit word and holds the CPU until the load ends.
module instruction_loader #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [19:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [15:0]       index;
  logic [7:0]        b0;
  logic [7:0]        b1;
  logic [ADDR_W-1:0] addr_q;
  logic [19:0]       data_q;

  logic              transfer;
  logic [15:0]       len_word;
  logic              len_bad;
  logic              b2_bad;
  logic [15:0]       index_inc;
  logic              last_word;

  assign transfer  = in_valid & in_ready;
  assign len_word  = {in_data, count[7:0]};
  assign len_bad   = (len_word == 16'd0) || (len_word > 16'(DEPTH));
  assign b2_bad    = (in_data[7:4] != 4'd0);
  assign index_inc = index + 16'd1;
  assign last_word = (index_inc == count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LEN_LO;
      LEN_LO: if (transfer) state_nxt = LEN_HI;
      LEN_HI: if (transfer) state_nxt = len_bad ? ERROR : B0;
      B0:     if (transfer) state_nxt = B1;
      B1:     if (transfer) state_nxt = B2;
      B2:     if (transfer) state_nxt = b2_bad ? ERROR : WRITE;
      WRITE:  state_nxt = last_word ? DONE : B0;
      DONE:   if (start) state_nxt = LEN_LO;
      ERROR:  if (start) state_nxt = LEN_LO;
      default: state_nxt = IDLE;
    endcase
  end

  // The write port is loaded as the third byte arrives, so it is stable
  // throughout WRITE and keeps its last value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      index  <= '0;
      b0     <= '0;
      b1     <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        LEN_LO: if (transfer) count[7:0] <= in_data;
        LEN_HI: begin
          if (transfer) begin
            count <= len_word;
            index <= '0;
          end
        end
        B0: if (transfer) b0 <= in_data;
        B1: if (transfer) b1 <= in_data;
        B2: begin
          if (transfer && !b2_bad) begin
            data_q <= {in_data[3:0], b1, b0};
            addr_q <= ADDR_W'(BASE_ADDR) + index[ADDR_W-1:0];
          end
        end
        WRITE: index <= index_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      LEN_LO, LEN_HI, B0, B1, B2: in_ready = 1'b1;
      WRITE: wr_en = 1'b1;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule
